// File: rtl/self_trigger_sequencer_pkg.sv
// Shared definitions for the self-triggered acquisition window sequencer.
package self_trigger_sequencer_pkg;

  localparam int unsigned DEFAULT_COUNT_WIDTH = 16;
  localparam int unsigned DEFAULT_EVENT_WIDTH = 16;

  // Encoding is visible on adcState for CSR readout.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_WINDOW  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

endpackage

// File: rtl/self_trigger_sequencer_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
// Ports: clk, rst_n (async active-low), clear_i, inc_i, count_o (registered count).
module self_trigger_sequencer_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: clear first, then increment unless pinned at all-ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/self_trigger_sequencer.sv
// Self-triggered acquisition window sequencer in the ADC clock domain.
// A rising edge of the threshold flag (across valid samples) opens a window of
// N valid samples; emits gate/start/end/abort strobes and keeps saturating
// trigger and missed-trigger counters.
// Ports: adcClk/adcResetN; control strobes adcArm, adcDisarm, adcClearCounts;
// config adcContinuous, adcWindowLength, adcHoldoff; sample adcValid,
// adcExceedsThreshold; registered outputs adcGate, adcWindowStart,
// adcWindowEnd, adcAborted, adcState, adcTriggerCount, adcMissedCount.
module self_trigger_sequencer
  import self_trigger_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int unsigned EVENT_WIDTH = DEFAULT_EVENT_WIDTH
) (
  input  logic                   adcClk,
  input  logic                   adcResetN,
  input  logic                   adcArm,
  input  logic                   adcDisarm,
  input  logic                   adcClearCounts,
  input  logic                   adcContinuous,
  input  logic [COUNT_WIDTH-1:0] adcWindowLength,
  input  logic [COUNT_WIDTH-1:0] adcHoldoff,
  input  logic                   adcValid,
  input  logic                   adcExceedsThreshold,
  output logic                   adcGate,
  output logic                   adcWindowStart,
  output logic                   adcWindowEnd,
  output logic                   adcAborted,
  output logic [1:0]             adcState,
  output logic [EVENT_WIDTH-1:0] adcTriggerCount,
  output logic [EVENT_WIDTH-1:0] adcMissedCount
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] win_cnt_q, win_cnt_d;   // samples still to gate after the current one
  logic [COUNT_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                   cont_q, cont_d;         // continuous mode captured at window end
  logic                   prev_flag_q, prev_flag_d;
  logic                   gate_q, gate_d;
  logic                   start_q, start_d;
  logic                   end_q, end_d;
  logic                   abort_q, abort_d;

  logic                   trigger_c;
  logic                   win_done_c;
  logic                   trig_inc_c;
  logic                   miss_inc_c;
  logic [COUNT_WIDTH-1:0] win_len_c;

  // Edge history advances only on valid samples; resets high to mask a flag already set.
  assign prev_flag_d = adcValid ? adcExceedsThreshold : prev_flag_q;
  assign trigger_c   = adcValid && adcExceedsThreshold && !prev_flag_q;
  assign win_len_c   = (adcWindowLength == '0) ? COUNT_WIDTH'(1) : adcWindowLength;

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cont_d     = cont_q;
    gate_d     = 1'b0;
    start_d    = 1'b0;
    end_d      = 1'b0;
    abort_d    = 1'b0;
    win_done_c = 1'b0;
    trig_inc_c = 1'b0;
    miss_inc_c = 1'b0;

    if (adcDisarm) begin
      state_d = ST_IDLE;
      abort_d = (state_q == ST_WINDOW);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (adcArm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (trigger_c) begin
            gate_d  = 1'b1;
            start_d = 1'b1;
            if (win_len_c == COUNT_WIDTH'(1)) begin
              win_done_c = 1'b1;
            end else begin
              win_cnt_d = win_len_c - COUNT_WIDTH'(1);
              state_d   = ST_WINDOW;
            end
          end
        end
        ST_WINDOW: begin
          if (adcValid) begin
            gate_d     = 1'b1;
            miss_inc_c = trigger_c;
            if (win_cnt_q <= COUNT_WIDTH'(1)) begin
              win_done_c = 1'b1;
            end else begin
              win_cnt_d = win_cnt_q - COUNT_WIDTH'(1);
            end
          end
        end
        ST_HOLDOFF: begin
          miss_inc_c = trigger_c;
          if (hold_cnt_q <= COUNT_WIDTH'(1)) begin
            hold_cnt_d = '0;
            state_d    = cont_q ? ST_ARMED : ST_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - COUNT_WIDTH'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Last gated sample: close the window and pick holdoff / re-arm / idle.
      if (win_done_c) begin
        end_d      = 1'b1;
        trig_inc_c = 1'b1;
        cont_d     = adcContinuous;
        hold_cnt_d = adcHoldoff;
        if (adcHoldoff != '0) begin
          state_d = ST_HOLDOFF;
        end else begin
          state_d = adcContinuous ? ST_ARMED : ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge adcClk or negedge adcResetN) begin
    if (!adcResetN) begin
      state_q     <= ST_IDLE;
      win_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      cont_q      <= 1'b0;
      prev_flag_q <= 1'b1;
      gate_q      <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_cnt_q   <= win_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      cont_q      <= cont_d;
      prev_flag_q <= prev_flag_d;
      gate_q      <= gate_d;
      start_q     <= start_d;
      end_q       <= end_d;
      abort_q     <= abort_d;
    end
  end

  self_trigger_sequencer_sat_counter #(.WIDTH(EVENT_WIDTH)) u_trig_cnt (
    .clk     (adcClk),
    .rst_n   (adcResetN),
    .clear_i (adcClearCounts),
    .inc_i   (trig_inc_c),
    .count_o (adcTriggerCount)
  );

  self_trigger_sequencer_sat_counter #(.WIDTH(EVENT_WIDTH)) u_miss_cnt (
    .clk     (adcClk),
    .rst_n   (adcResetN),
    .clear_i (adcClearCounts),
    .inc_i   (miss_inc_c),
    .count_o (adcMissedCount)
  );

  assign adcGate        = gate_q;
  assign adcWindowStart = start_q;
  assign adcWindowEnd   = end_q;
  assign adcAborted     = abort_q;
  assign adcState       = state_q;

endmodule

// File: tb/tb_self_trigger_sequencer.sv
// Scoreboard bench for self_trigger_sequencer: stimulus pushes expected strobe
// records tagged with the output cycle; a monitor pops them whenever any strobe
// is seen. Counters are narrowed to 4 bits so saturation is reachable quickly.
module tb_self_trigger_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned EW = 4;

  localparam logic [2:0] NONE = 3'b000;
  localparam logic [2:0] ARM  = 3'b100;
  localparam logic [2:0] DIS  = 3'b010;
  localparam logic [2:0] CLR  = 3'b001;

  // Expected strobes {gate, start, end, aborted}
  localparam logic [3:0] E0  = 4'b0000;
  localparam logic [3:0] G   = 4'b1000;
  localparam logic [3:0] GS  = 4'b1100;
  localparam logic [3:0] GE  = 4'b1010;
  localparam logic [3:0] GSE = 4'b1110;
  localparam logic [3:0] AB  = 4'b0001;

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  flags;
  } exp_t;

  logic          adcClk = 1'b0;
  logic          adcResetN;
  logic          adcArm, adcDisarm, adcClearCounts, adcContinuous;
  logic [CW-1:0] adcWindowLength, adcHoldoff;
  logic          adcValid, adcExceedsThreshold;
  logic          adcGate, adcWindowStart, adcWindowEnd, adcAborted;
  logic [1:0]    adcState;
  logic [EW-1:0] adcTriggerCount, adcMissedCount;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];

  self_trigger_sequencer #(.COUNT_WIDTH(CW), .EVENT_WIDTH(EW)) dut (
    .adcClk              (adcClk),
    .adcResetN           (adcResetN),
    .adcArm              (adcArm),
    .adcDisarm           (adcDisarm),
    .adcClearCounts      (adcClearCounts),
    .adcContinuous       (adcContinuous),
    .adcWindowLength     (adcWindowLength),
    .adcHoldoff          (adcHoldoff),
    .adcValid            (adcValid),
    .adcExceedsThreshold (adcExceedsThreshold),
    .adcGate             (adcGate),
    .adcWindowStart      (adcWindowStart),
    .adcWindowEnd        (adcWindowEnd),
    .adcAborted          (adcAborted),
    .adcState            (adcState),
    .adcTriggerCount     (adcTriggerCount),
    .adcMissedCount      (adcMissedCount)
  );

  always #5 adcClk = ~adcClk;
  always @(posedge adcClk) cyc <= cyc + 1;

  task automatic chk(input string name, input int unsigned act, input int unsigned expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One input cycle; called and returns 1 time unit after a rising edge.
  task automatic step(input logic v, input logic f, input logic [2:0] ctl, input logic [3:0] e);
    exp_t rec;
    adcValid = v;
    adcExceedsThreshold = f;
    {adcArm, adcDisarm, adcClearCounts} = ctl;
    if (e != E0) begin
      rec.cyc   = cyc + 1;
      rec.flags = e;
      exp_q.push_back(rec);
    end
    @(posedge adcClk);
    #1;
    adcArm = 1'b0;
    adcDisarm = 1'b0;
    adcClearCounts = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_gate"},   32'(adcGate), 0);
    chk({tag, "_start"},  32'(adcWindowStart), 0);
    chk({tag, "_end"},    32'(adcWindowEnd), 0);
    chk({tag, "_abort"},  32'(adcAborted), 0);
    chk({tag, "_state"},  32'(adcState), 0);
    chk({tag, "_trig"},   32'(adcTriggerCount), 0);
    chk({tag, "_missed"}, 32'(adcMissedCount), 0);
  endtask

  // Monitor: any strobe must match the oldest expectation, including its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge adcClk);
      if (adcGate || adcWindowStart || adcWindowEnd || adcAborted) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_unexpected cycle=%0d got gse_a=%b%b%b%b expected none",
                   cyc, adcGate, adcWindowStart, adcWindowEnd, adcAborted);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.flags != {adcGate, adcWindowStart, adcWindowEnd, adcAborted}) begin
            failures++;
            $display("FAIL scoreboard cycle=%0d got gse_a=%b%b%b%b expected cycle=%0d gse_a=%b",
                     cyc, adcGate, adcWindowStart, adcWindowEnd, adcAborted, e.cyc, e.flags);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        checks++;
        failures++;
        e = exp_q.pop_front();
        $display("FAIL scoreboard_missing cycle=%0d got no strobe expected gse_a=%b", cyc, e.flags);
      end
    end
  end

  initial begin
    adcResetN = 1'b1;
    adcArm = 1'b0; adcDisarm = 1'b0; adcClearCounts = 1'b0;
    adcContinuous = 1'b0; adcWindowLength = CW'(4); adcHoldoff = '0;
    adcValid = 1'b0; adcExceedsThreshold = 1'b0;
    #2 adcResetN = 1'b0;
    #1 check_reset_values("reset");
    repeat (3) @(posedge adcClk);
    #1 adcResetN = 1'b1;

    // Single shot, length 4, flag 0,0,1,1,1,1,0
    step(0, 0, ARM, E0);
    chk("t1_armed", 32'(adcState), 1);
    step(1, 0, NONE, E0);
    step(1, 0, NONE, E0);
    step(1, 1, NONE, GS);
    step(1, 1, NONE, G);
    step(1, 1, NONE, G);
    step(1, 1, NONE, GE);
    step(1, 0, NONE, E0);
    chk("t1_idle", 32'(adcState), 0);
    chk("t1_trig", 32'(adcTriggerCount), 1);

    // Valid every other cycle, length 3
    adcWindowLength = CW'(3);
    step(1, 0, ARM, E0);
    step(1, 1, NONE, GS);
    step(0, 0, NONE, E0);
    step(1, 1, NONE, G);
    step(0, 1, NONE, E0);
    step(1, 1, NONE, GE);
    step(0, 0, NONE, E0);
    chk("t2_idle", 32'(adcState), 0);
    chk("t2_trig", 32'(adcTriggerCount), 2);

    // Continuous, length 2, holdoff 5: edge at end+3 missed, edge at end+6 accepted
    adcContinuous = 1'b1; adcWindowLength = CW'(2); adcHoldoff = CW'(5);
    step(1, 0, ARM, E0);
    step(1, 1, NONE, GS);
    step(1, 0, NONE, GE);   // window end sample
    step(1, 0, NONE, E0);
    step(0, 0, NONE, E0);
    step(1, 1, NONE, E0);   // end+3: inside holdoff
    step(1, 0, NONE, E0);
    step(0, 0, NONE, E0);
    step(1, 1, NONE, GS);   // end+6: re-armed
    step(1, 1, NONE, GE);
    chk("t3_holdoff", 32'(adcState), 3);
    chk("t3_missed", 32'(adcMissedCount), 1);
    chk("t3_trig", 32'(adcTriggerCount), 4);
    step(0, 0, DIS, E0);
    chk("t3_disarm_idle", 32'(adcState), 0);

    // Abort on 2nd sample of length-8 window; arm+disarm together stays idle
    step(0, 0, CLR, E0);
    chk("t4_clr_trig", 32'(adcTriggerCount), 0);
    chk("t4_clr_missed", 32'(adcMissedCount), 0);
    adcContinuous = 1'b0; adcWindowLength = CW'(8); adcHoldoff = '0;
    step(1, 0, ARM, E0);
    step(1, 1, NONE, GS);
    step(1, 1, DIS, AB);
    step(1, 0, NONE, E0);
    chk("t4_abort_idle", 32'(adcState), 0);
    chk("t4_abort_trig", 32'(adcTriggerCount), 0);
    step(0, 0, ARM | DIS, E0);
    chk("t4_armdis_idle", 32'(adcState), 0);
    step(1, 1, NONE, E0);
    chk("t4_idle_no_miss", 32'(adcMissedCount), 0);

    // Reset mid-window with flag high; flag held high through release must not trigger
    step(1, 0, ARM, E0);
    step(1, 1, NONE, GS);
    @(negedge adcClk);
    adcResetN = 1'b0;
    #1 check_reset_values("midwin_reset");
    repeat (2) @(posedge adcClk);
    #1 adcResetN = 1'b1;
    adcWindowLength = '0;   // zero length acts as one sample
    step(1, 1, ARM, E0);
    chk("t5_armed", 32'(adcState), 1);
    step(1, 1, NONE, E0);
    chk("t5_still_armed", 32'(adcState), 1);
    step(1, 0, NONE, E0);
    step(1, 1, NONE, GSE);
    chk("t5_idle", 32'(adcState), 0);
    chk("t5_trig", 32'(adcTriggerCount), 1);

    // Saturation: 16 more one-sample windows on a 4-bit counter
    adcContinuous = 1'b1; adcWindowLength = CW'(1); adcHoldoff = '0;
    step(1, 0, ARM, E0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, NONE, GSE);
      step(1, 0, NONE, E0);
    end
    chk("t6_sat", 32'(adcTriggerCount), 15);
    step(1, 1, CLR, GSE);   // clear coincides with window end
    chk("t6_clear_wins", 32'(adcTriggerCount), 0);

    // Holdoff 0, continuous: trigger on the sample right after window end
    adcWindowLength = CW'(2);
    step(1, 0, NONE, E0);
    step(1, 1, NONE, GS);
    step(1, 0, NONE, GE);
    step(1, 1, NONE, GS);
    step(1, 0, NONE, GE);
    chk("t6_backtoback_trig", 32'(adcTriggerCount), 2);
    chk("t6_armed", 32'(adcState), 1);
    step(0, 0, DIS, E0);
    chk("t6_disarm_idle", 32'(adcState), 0);

    step(0, 0, NONE, E0);
    step(0, 0, NONE, E0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/self_trigger_sequencer.md
# self_trigger_sequencer

Sequences single-pass self-triggered acquisition windows in the ADC clock domain. Consumes the per-sample threshold flag from ADC processing and generates the accumulation gate and start/end strobes for the downstream RMS/summation blocks. Supports arm/disarm, single-shot or continuous re-arm, programmable window length and holdoff, and saturating trigger and missed-trigger counters for CSR readout. Configuration arrives already forwarded into adcClk.

## Interface
- COUNT_WIDTH, 16: width of window-length and holdoff fields.
- EVENT_WIDTH, 16: width of trigger/missed counters.

Ports:
- adcClk  in  1  ADC clock; the only clock.
- adcResetN  in  1  reset, asynchronous assert, active-low.
- adcArm  in  1  one-cycle arm request.
- adcDisarm  in  1  one-cycle abort/disarm request.
- adcClearCounts  in  1  one-cycle counter clear.
- adcContinuous  in  1  1: re-arm after each window; 0: single shot.
- adcWindowLength  in  COUNT_WIDTH  valid samples per window; 0 treated as 1.
- adcHoldoff  in  COUNT_WIDTH  adcClk cycles between window end and re-arm.
- adcValid  in  1  sample strobe.
- adcExceedsThreshold  in  1  threshold flag, qualified by adcValid.
- adcGate  out  1  accumulate this sample (registered).
- adcWindowStart  out  1  one-cycle pulse on first gated sample.
- adcWindowEnd  out  1  one-cycle pulse on last gated sample.
- adcAborted  out  1  one-cycle pulse when a window is cut by disarm.
- adcState  out  2  current state encoding.
- adcTriggerCount  out  EVENT_WIDTH  completed windows, saturating.
- adcMissedCount  out  EVENT_WIDTH  triggers ignored while busy, saturating.

## Operation
- Trigger = rising edge of adcExceedsThreshold across consecutive valid samples (previous valid sample flag 0, current 1). Edge history updates only on adcValid; reset history = 1 so a flag already high after reset does not trigger.
- States: IDLE=0, ARMED=1, WINDOW=2, HOLDOFF=3.
- IDLE: adcArm -> ARMED. Otherwise hold.
- ARMED: trigger -> WINDOW; latch max(adcWindowLength,1) into window counter; gate the trigger sample.
- WINDOW: gate every valid sample; count valid samples only. On the Nth gated sample assert adcWindowEnd, increment adcTriggerCount, latch adcHoldoff; go HOLDOFF if holdoff≠0, else ARMED (continuous) or IDLE.
- HOLDOFF: decrement per adcClk cycle; on reaching 0 go ARMED (continuous) or IDLE.
- Triggers in WINDOW (other than the starting one) or HOLDOFF increment adcMissedCount.
- adcDisarm from any state -> IDLE next cycle; if in WINDOW, pulse adcAborted, no adcWindowEnd, no trigger count. Disarm beats arm in the same cycle. Arm outside IDLE is ignored.
- Config changes mid-window/holdoff have no effect until next latch.
- adcClearCounts zeroes both counters; a simultaneous increment is lost (clear wins).
- Counters saturate at all-ones.
- Reset mid-window: all outputs to reset values immediately; no pulses.

## Timing
- Reset values: adcGate, adcWindowStart, adcWindowEnd, adcAborted = 0; adcState = IDLE; both counters = 0.
- All outputs registered: sample presented at cycle t yields adcGate/adcWindowStart/adcWindowEnd at t+1; downstream aligns data with a 1-cycle delay.
- adcGate high only on cycles following a valid input; 1-sample window: adcWindowStart and adcWindowEnd coincide.
- Holdoff H: earliest next trigger sample is H+1 cycles after the window-end sample.
- With holdoff 0 and continuous mode, a trigger on the sample after window end starts a new window.

## Structure
- Shared package: state encoding constants (IDLE/ARMED/WINDOW/HOLDOFF), default widths.
- One sub-module: sat_counter (EVENT_WIDTH, inc, clear, clear-wins, saturating), instantiated twice.
- FSM, window/holdoff counters and edge detector live in the top module.

## Test plan
- Arm, length 4, holdoff 0, single shot, flag 0,0,1,1,1,1,0 on consecutive valid cycles -> gate on exactly 4 samples, start with 1st, end with 4th, state IDLE, triggerCount=1.
- adcValid every other cycle, length 3 -> gate spans 3 valid samples over 5 cycles, never on invalid cycles.
- Continuous, length 2, holdoff 5, second edge 3 cycles after end -> missedCount=1; edge 6 cycles after end -> second window, triggerCount=2.
- Disarm during 2nd sample of a length-8 window -> adcAborted pulse, gate drops next cycle, triggerCount unchanged, state IDLE; arm+disarm same cycle -> stays IDLE.
- Flag held high through reset release then arm -> no trigger until flag falls and rises again.
- Force triggerCount to all-ones, complete window -> stays all-ones; adcClearCounts coincident with window end -> 0.
